bus_slave_port: RTL

- Serial responder endpoint for the system bus; the slave-side counterpart of the bus master port.
- Receives a bit-serial address/mode/write-data frame from the arbitrated master, performs a local memory access, and returns read data serially.
- Optionally splits a read: releases the bus and later re-requests it through the arbiter.
- Sits between the bus interconnect/arbiter and a local synchronous RAM (one-cycle read latency) in each slave.

---
 rtl/bus_slave_port.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/bus_slave_port.sv
// Bus slave port: receives a serial address/mode/write-data frame, accesses local
// synchronous RAM, and returns read data serially, optionally as a split transaction.
module bus_slave_port #(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int SPLIT_EN      = 0,
  parameter int SPLIT_LATENCY = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  mode,
  input  logic                  mvalid,
  input  logic                  mwdata,
  output logic                  sready,
  output logic                  svalid,
  output logic                  mrdata,
  output logic                  split_req,
  input  logic                  split_grant,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int SW      = $clog2(SPLIT_LATENCY + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, MEMWR, MEMRD, SPLIT_WAIT, SPLIT_REQ, RDATA
  } state_t;

  localparam state_t RD_ENTRY = (SPLIT_EN != 0) ? SPLIT_WAIT : MEMRD;

  // RAM read progress: 0 = address presented, 1 = data valid (latch), 2 = latched
  typedef enum logic [1:0] {RD_ADDR, RD_LATCH, RD_DONE} rdstep_t;

  state_t                state_q,  state_d;
  rdstep_t               rdstep_q, rdstep_d;
  logic                  mode_q,   mode_d;
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
  logic [DATA_WIDTH-1:0] shreg_q,  shreg_d;
  logic [CW-1:0]         bcnt_q,   bcnt_d;
  logic [SW-1:0]         scnt_q,   scnt_d;
  logic [ADDR_WIDTH-1:0] addr_shift;
  logic [DATA_WIDTH-1:0] wdata_shift;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      rdstep_q <= RD_ADDR;
      mode_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      shreg_q  <= '0;
      bcnt_q   <= '0;
      scnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      rdstep_q <= rdstep_d;
      mode_q   <= mode_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      shreg_q  <= shreg_d;
      bcnt_q   <= bcnt_d;
      scnt_q   <= scnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rdstep_d  = rdstep_q;
    mode_d    = mode_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    shreg_d   = shreg_q;
    bcnt_d    = bcnt_q;
    scnt_d    = scnt_q;
    sready    = 1'b0;
    svalid    = 1'b0;
    mrdata    = 1'b0;
    split_req = 1'b0;
    mem_wen   = 1'b0;

    // LSB-first: each new bit enters at the top and the word shifts right
    addr_shift                 = addr_q >> 1;
    addr_shift[ADDR_WIDTH-1]   = mwdata;
    wdata_shift                = wdata_q >> 1;
    wdata_shift[DATA_WIDTH-1]  = mwdata;

    unique case (state_q)
      IDLE: begin
        sready = 1'b1;
        if (mvalid) begin
          mode_d = mode;
          addr_d = addr_shift;
          if (ADDR_WIDTH == 1) begin
            bcnt_d   = '0;
            rdstep_d = RD_ADDR;
            scnt_d   = '0;
            state_d  = mode ? WDATA : RD_ENTRY;
          end else begin
            bcnt_d  = CW'(1);
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        if (mvalid) begin
          addr_d = addr_shift;
          if (bcnt_q == CW'(ADDR_WIDTH - 1)) begin
            bcnt_d   = '0;
            rdstep_d = RD_ADDR;
            scnt_d   = '0;
            state_d  = mode_q ? WDATA : RD_ENTRY;
          end else begin
            bcnt_d = bcnt_q + CW'(1);
          end
        end
      end
      WDATA: begin
        if (mvalid) begin
          wdata_d = wdata_shift;
          if (bcnt_q == CW'(DATA_WIDTH - 1)) begin
            bcnt_d  = '0;
            state_d = MEMWR;
          end else begin
            bcnt_d = bcnt_q + CW'(1);
          end
        end
      end
      MEMWR: begin
        mem_wen = 1'b1;
        state_d = IDLE;
      end
      MEMRD: begin
        if (rdstep_q == RD_ADDR) begin
          rdstep_d = RD_LATCH;
        end else begin
          shreg_d  = mem_rdata;
          rdstep_d = RD_DONE;
          bcnt_d   = '0;
          state_d  = RDATA;
        end
      end
      SPLIT_WAIT: begin
        sready = 1'b1;
        if (scnt_q == SW'(SPLIT_LATENCY - 1)) begin
          scnt_d  = '0;
          state_d = SPLIT_REQ;
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end
      SPLIT_REQ: begin
        sready    = 1'b1;
        split_req = 1'b1;
        if (split_grant) begin
          bcnt_d  = '0;
          state_d = RDATA;
        end
      end
      RDATA: begin
        svalid  = 1'b1;
        mrdata  = shreg_q[0];
        shreg_d = shreg_q >> 1;
        if (bcnt_q == CW'(DATA_WIDTH - 1)) begin
          bcnt_d  = '0;
          state_d = IDLE;
        end else begin
          bcnt_d = bcnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Split reads run the RAM access alongside the latency count; with a very short
    // latency the latch can land in SPLIT_REQ, even on the grant cycle itself.
    if ((state_q == SPLIT_WAIT || state_q == SPLIT_REQ) && rdstep_q != RD_DONE) begin
      if (rdstep_q == RD_ADDR) begin
        rdstep_d = RD_LATCH;
      end else begin
        shreg_d  = mem_rdata;
        rdstep_d = RD_DONE;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
